// File: rtl/wb_pkg.sv
// Purpose : shared enumerations and default parameters for the writeback/commit stage.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package wb_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 2;
  localparam int DEF_CSR_AW = 14;

  typedef enum logic [1:0] {
    RES_ALU = 2'd0,
    RES_MEM = 2'd1,
    RES_CSR = 2'd2,
    RES_CNT = 2'd3
  } res_sel_e;

  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_B  = 3'd1,
    LD_H  = 3'd2,
    LD_BU = 3'd3,
    LD_HU = 3'd4,
    LD_D  = 3'd5
  } ld_op_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,  // no instruction held
    ST_HOLD  = 2'd1,  // instruction held, waiting on a data-SRAM response
    ST_READY = 2'd2   // instruction held, result already known
  } wb_state_e;

endpackage

// File: rtl/wb_commit_stage_if.sv
// Purpose : MEM -> WB instruction handoff bundle with valid/ready handshake.
// Latency : n/a (wires only).
// Backpressure: producer holds in_* stable while in_valid && !in_ready.
// Ports   : master = MEM side (drives instruction fields), slave = WB side (drives in_ready).
interface wb_commit_stage_if import wb_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_pc;
  logic              in_gr_we;
  logic [4:0]        in_dest;
  logic [1:0]        in_res_sel;
  logic [2:0]        in_ld_op;
  logic              in_wait_data;
  logic [DATA_W-1:0] in_result;

  modport master (
    output in_valid, in_pc, in_gr_we, in_dest, in_res_sel, in_ld_op, in_wait_data, in_result,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_pc, in_gr_we, in_dest, in_res_sel, in_ld_op, in_wait_data, in_result,
    output in_ready
  );
endinterface

// File: rtl/wb_resp_fifo.sv
// Purpose : DEPTH-entry buffer for load responses that arrive before their load retires.
// Latency : push visible at head the cycle after the write edge.
// Backpressure: none; caller must not push when full unless popping the same cycle.
// Ports   : clk/reset, push+wdata, pop, rdata (head), full, empty.
module wb_resp_fifo import wb_pkg::*; #(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count;

  // Explicit wrap so non-power-of-two depths work too.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/wb_commit_stage.sv
// Purpose : registered writeback/commit stage: RF write, debug trace, forwarding to ID.
// Latency : accepted at edge N -> rf_we in cycle N+1 earliest; 1 retire/cycle sustained.
// Backpressure: in_ready low while a held instruction cannot retire or during flush.
// Ports   : clk/reset, mem_in (MEM handoff, slave), data_ok/data_rdata (SRAM response),
//           flush, rf_* write port, fwd_* bundle, debug_wb_*, retire_cnt, resp_ovf.
module wb_commit_stage import wb_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int CSR_AW = DEF_CSR_AW
) (
  input  logic                clk,
  input  logic                reset,
  wb_commit_stage_if.slave    mem_in,
  input  logic                data_ok,
  input  logic [DATA_W-1:0]   data_rdata,
  input  logic                flush,
  output logic                rf_we,
  output logic [4:0]          rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic                fwd_valid,
  output logic                fwd_busy,
  output logic [4:0]          fwd_dest,
  output logic [DATA_W-1:0]   fwd_data,
  output logic [31:0]         debug_wb_pc,
  output logic [3:0]          debug_wb_rf_we,
  output logic [4:0]          debug_wb_rf_wnum,
  output logic [DATA_W-1:0]   debug_wb_rf_wdata,
  output logic [31:0]         retire_cnt,
  output logic                resp_ovf
);
  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int CW    = $clog2(DEPTH + 1);

  // CSR address width is carried for interface compatibility only.
  wire unused_csr_aw = |CSR_AW;

  wb_state_e         st_q, st_d;
  logic [31:0]       pc_q;
  logic              gr_we_q;
  logic [4:0]        dest_q;
  res_sel_e          sel_q;
  ld_op_e            ld_q;
  logic [DATA_W-1:0] res_q;
  logic [CW-1:0]     cancel_q;

  logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [DATA_W-1:0] fifo_rdata;
  logic              stage_valid, no_cancel, bypass, available, retire, in_ready_c, accept;
  logic              push_req, drop_ovf, cancel_inc, cancel_dec, cancel_sat;
  logic [DATA_W-1:0] raw, shifted, ld_val, final_res;

  // Response routing: responses owed to cancelled loads are dropped first; otherwise
  // a held load with an empty buffer takes the response directly (even when it is
  // being flushed, in which case the response is simply its own and is discarded).
  assign stage_valid = (st_q != ST_EMPTY);
  assign no_cancel   = (cancel_q == '0);
  assign bypass      = (st_q == ST_HOLD) && fifo_empty && data_ok && no_cancel;
  assign available   = (st_q == ST_READY) || ((st_q == ST_HOLD) && (!fifo_empty || bypass));
  assign retire      = stage_valid && available && !flush;
  assign accept      = mem_in.in_valid && in_ready_c;

  assign push_req    = data_ok && no_cancel && !bypass;
  assign fifo_pop    = (st_q == ST_HOLD) && !fifo_empty && (retire || flush);
  // A full buffer can still take a push when the head leaves the same cycle.
  assign fifo_push   = push_req && (!fifo_full || fifo_pop);
  assign drop_ovf    = push_req && fifo_full && !fifo_pop;
  assign cancel_dec  = data_ok && !no_cancel;
  assign cancel_inc  = flush && (st_q == ST_HOLD) && fifo_empty && !bypass;
  assign cancel_sat  = cancel_inc && !cancel_dec && (cancel_q == CW'(DEPTH));

  wb_resp_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_resp_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata (data_rdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Load extraction: align the addressed byte lane to bit 0, then extend.
  always_comb begin
    raw     = bypass ? data_rdata : fifo_rdata;
    shifted = raw >> {res_q[OFF_W-1:0], 3'b000};
    ld_val  = shifted;
    case (ld_q)
      LD_B:    begin ld_val = {DATA_W{shifted[7]}};  ld_val[7:0]  = shifted[7:0];  end
      LD_BU:   begin ld_val = '0;                    ld_val[7:0]  = shifted[7:0];  end
      LD_H:    begin ld_val = {DATA_W{shifted[15]}}; ld_val[15:0] = shifted[15:0]; end
      LD_HU:   begin ld_val = '0;                    ld_val[15:0] = shifted[15:0]; end
      LD_D:    ld_val = shifted;
      default: begin ld_val = {DATA_W{shifted[31]}}; ld_val[31:0] = shifted[31:0]; end
    endcase
    final_res = (sel_q == RES_MEM) ? ld_val : res_q;
  end

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) st_q <= ST_EMPTY;
    else       st_q <= st_d;
  end

  // FSM: next state (flush suppresses accept through in_ready)
  always_comb begin
    st_d = st_q;
    if (accept)               st_d = mem_in.in_wait_data ? ST_HOLD : ST_READY;
    else if (flush || retire) st_d = ST_EMPTY;
  end

  // FSM: outputs
  always_comb begin
    in_ready_c = !flush && (!stage_valid || retire);
    rf_we      = retire && gr_we_q;
    fwd_valid  = stage_valid && gr_we_q;
    fwd_busy   = fwd_valid && !available;
  end

  assign mem_in.in_ready   = in_ready_c;
  assign rf_waddr          = dest_q;
  assign rf_wdata          = final_res;
  assign fwd_dest          = dest_q;
  assign fwd_data          = final_res;
  assign debug_wb_pc       = pc_q;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = dest_q;
  assign debug_wb_rf_wdata = final_res;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= '0;
      gr_we_q    <= 1'b0;
      dest_q     <= '0;
      sel_q      <= RES_ALU;
      ld_q       <= LD_W;
      res_q      <= '0;
      cancel_q   <= '0;
      retire_cnt <= '0;
      resp_ovf   <= 1'b0;
    end else begin
      if (accept) begin
        pc_q    <= mem_in.in_pc;
        gr_we_q <= mem_in.in_gr_we;
        dest_q  <= mem_in.in_dest;
        sel_q   <= res_sel_e'(mem_in.in_res_sel);
        ld_q    <= ld_op_e'(mem_in.in_ld_op);
        res_q   <= mem_in.in_result;
      end
      if (retire) retire_cnt <= retire_cnt + 32'd1;
      // A drop and a new cancellation in the same cycle leave the count unchanged.
      if (cancel_dec && !cancel_inc)                     cancel_q <= cancel_q - 1'b1;
      else if (cancel_inc && !cancel_dec && !cancel_sat) cancel_q <= cancel_q + 1'b1;
      if (drop_ovf || cancel_sat) resp_ovf <= 1'b1;
    end
  end
endmodule
